// File: rtl/muldiv_seq_ctrl.sv
// Multiply/divide sequencer for the MIPS MDU: owns HI/LO, runs MULTU as
// shift-add and DIVU as restoring divide over WIDTH iterations each.
module muldiv_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             rd_req,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10
  } state_t;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_DIVU  = 2'b01;
  localparam logic [1:0] OP_MTHI  = 2'b10;
  localparam logic [1:0] OP_MTLO  = 2'b11;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] p_hi;
  logic [WIDTH-1:0] p_lo;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;

  logic             last;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_next;
  logic [WIDTH-1:0] mul_lo_next;
  logic [WIDTH:0]   rem_shift;
  logic             no_borrow;
  logic [WIDTH-1:0] trial;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  // One shift-add and one restoring-divide iteration, computed from current state.
  always_comb begin
    mul_sum     = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    mul_hi_next = mul_sum[WIDTH:1];
    mul_lo_next = {mul_sum[0], p_lo[WIDTH-1:1]};
    rem_shift   = {rem, quo[WIDTH-1]};
    // The remainder after a successful subtract is below the divisor, so WIDTH bits hold it.
    no_borrow   = (rem_shift >= {1'b0, divisor});
    trial       = rem_shift[WIDTH-1:0] - divisor;
    if (no_borrow) begin
      rem_next = trial;
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = rem_shift[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
    last = (count == CNT_W'(WIDTH - 1));
  end

  // Next-state selection; a start is only honoured from IDLE.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start && (op == OP_MULTU)) begin
          state_next = S_MUL;
        end else if (start && (op == OP_DIVU)) begin
          state_next = S_DIV;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_MUL: begin
        if (last) begin
          state_next = S_IDLE;
        end else begin
          state_next = S_MUL;
        end
      end
      S_DIV: begin
        if (last) begin
          state_next = S_IDLE;
        end else begin
          state_next = S_DIV;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Working registers, HI/LO and the done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= {CNT_W{1'b0}};
      mcand   <= {WIDTH{1'b0}};
      p_hi    <= {WIDTH{1'b0}};
      p_lo    <= {WIDTH{1'b0}};
      divisor <= {WIDTH{1'b0}};
      rem     <= {WIDTH{1'b0}};
      quo     <= {WIDTH{1'b0}};
      hi_out  <= {WIDTH{1'b0}};
      lo_out  <= {WIDTH{1'b0}};
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            case (op)
              OP_MULTU: begin
                mcand <= rs_val;
                p_hi  <= {WIDTH{1'b0}};
                p_lo  <= rt_val;
                count <= {CNT_W{1'b0}};
              end
              OP_DIVU: begin
                divisor <= rt_val;
                rem     <= {WIDTH{1'b0}};
                quo     <= rs_val;
                count   <= {CNT_W{1'b0}};
              end
              OP_MTHI: hi_out <= rs_val;
              OP_MTLO: lo_out <= rs_val;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          p_hi  <= mul_hi_next;
          p_lo  <= mul_lo_next;
          count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
          if (last) begin
            hi_out <= mul_hi_next;
            lo_out <= mul_lo_next;
            done   <= 1'b1;
          end
        end
        S_DIV: begin
          rem   <= rem_next;
          quo   <= quo_next;
          count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
          if (last) begin
            hi_out <= rem_next;
            lo_out <= quo_next;
            done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy  = (state != S_IDLE);
  assign stall = rd_req & busy;

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Directed bench for muldiv_seq_ctrl: hand-computed HI/LO results, latency,
// done/stall behaviour, ignored starts and mid-operation reset.
module tb_muldiv_seq_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        rd_req;
  logic        busy;
  logic        done;
  logic        stall;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int n_cmp  = 0;
  int n_fail = 0;

  muldiv_seq_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .rd_req (rd_req),
    .busy   (busy),
    .done   (done),
    .stall  (stall),
    .hi_out (hi_out),
    .lo_out (lo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the start edge E0.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts busy cycles; optionally injects an ignored DIVU 9/3 at busy cycle inject_at.
  task automatic wait_busy(input int inject_at, input logic [31:0] hold_hi,
                           input logic [31:0] hold_lo, output int cyc,
                           output int stl, output int dn, output int held_bad);
    cyc = 0; stl = 0; dn = 0; held_bad = 0;
    while (busy && cyc < 40) begin
      cyc++;
      if (stall) stl++;
      if (done) dn++;
      if (hi_out !== hold_hi || lo_out !== hold_lo) held_bad++;
      if (cyc == inject_at) begin
        start = 1'b1; op = 2'b01; rs_val = 32'd9; rt_val = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int inject_at);
    int cyc, stl, dn, held_bad;
    logic [31:0] pre_hi, pre_lo;
    pre_hi = hi_out;
    pre_lo = lo_out;
    issue(o, a, b);
    chk({tag, " busy_after_E0"}, {31'd0, busy}, 32'd1);
    wait_busy(inject_at, pre_hi, pre_lo, cyc, stl, dn, held_bad);
    chk({tag, " busy_cycles"}, cyc, 32'd32);
    chk({tag, " early_done"}, dn, 32'd0);
    chk({tag, " hilo_held"}, held_bad, 32'd0);
    chk({tag, " done_pulse"}, {31'd0, done}, 32'd1);
    chk({tag, " hi"}, hi_out, exp_hi);
    chk({tag, " lo"}, lo_out, exp_lo);
    @(negedge clk);
    chk({tag, " done_drop"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int cyc, stl, dn, held_bad;
    reset = 1'b1; start = 1'b0; op = 2'b00; rs_val = 32'd0; rt_val = 32'd0; rd_req = 1'b0;
    @(negedge clk);
    // Reset beats a simultaneous start.
    start = 1'b1; op = 2'b00; rs_val = 32'd5; rt_val = 32'd5;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst hi", hi_out, 32'd0);
    chk("rst lo", lo_out, 32'd0);
    @(negedge clk);
    chk("rst still_idle", {31'd0, busy}, 32'd0);

    run_op("mul_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);

    // DIVU 100/7 with rd_req held: no stall on the issuing cycle, stall all through busy.
    rd_req = 1'b1;
    start = 1'b1; op = 2'b01; rs_val = 32'd100; rt_val = 32'd7;
    #1;
    chk("div100 issue_stall", {31'd0, stall}, 32'd0);
    chk("div100 issue_pre_hi", hi_out, 32'hFFFF_FFFE);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_busy(0, 32'hFFFF_FFFE, 32'h0000_0001, cyc, stl, dn, held_bad);
    chk("div100 cycles", cyc, 32'd32);
    chk("div100 stalls", stl, 32'd32);
    chk("div100 held", held_bad, 32'd0);
    chk("div100 done", {31'd0, done}, 32'd1);
    chk("div100 stall_after", {31'd0, stall}, 32'd0);
    chk("div100 hi", hi_out, 32'd2);
    chk("div100 lo", lo_out, 32'd14);
    rd_req = 1'b0;
    @(negedge clk);

    run_op("div0", 2'b01, 32'd5, 32'd0, 32'h0000_0005, 32'hFFFF_FFFF, 0);

    // MTHI then MTLO on consecutive edges.
    start = 1'b1; op = 2'b10; rs_val = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    chk("mthi hi", hi_out, 32'h1234_5678);
    chk("mthi lo_kept", lo_out, 32'hFFFF_FFFF);
    chk("mthi busy", {31'd0, busy}, 32'd0);
    chk("mthi done", {31'd0, done}, 32'd0);
    op = 2'b11; rs_val = 32'h9ABC_DEF0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("mtlo lo", lo_out, 32'h9ABC_DEF0);
    chk("mtlo hi_kept", hi_out, 32'h1234_5678);
    chk("mtlo busy", {31'd0, busy}, 32'd0);
    chk("mtlo done", {31'd0, done}, 32'd0);

    run_op("mul_inj", 2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 10);
    chk("mul_inj idle_after", {31'd0, busy}, 32'd0);

    // Reset at busy cycle 5 of MULTU 6x7.
    issue(2'b00, 32'd6, 32'd7);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort hi", hi_out, 32'd0);
    chk("abort lo", lo_out, 32'd0);
    dn = 0;
    for (int i = 0; i < 35; i++) begin
      if (done) dn++;
      @(negedge clk);
    end
    chk("abort no_done", dn, 32'd0);

    run_op("mul_2x3", 2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_seq_ctrl.md
Name: muldiv_seq_ctrl

Overview:
Sequencing controller and HI/LO owner for the MIPS multiply/divide unit. It accepts MULTU, DIVU, MTHI and MTLO requests from the execute stage. MULTU runs as a shift-add over WIDTH iterations; DIVU runs as a restoring divide over WIDTH iterations. The block commits results to its internal HI/LO registers and raises busy/stall so the pipeline holds MFHI/MFLO until results are valid.

Parameters:
WIDTH, 32, operand width; HI/LO are WIDTH bits each; iteration count = WIDTH
CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request strobe, sampled on the clock edge
op  input  2  operation: 00 MULTU, 01 DIVU, 10 MTHI, 11 MTLO
rs_val  input  WIDTH  operand A (multiplicand/dividend/move source)
rt_val  input  WIDTH  operand B (multiplier/divisor)
rd_req  input  1  execute stage is issuing MFHI/MFLO this cycle
busy  output  1  iteration in progress
done  output  1  one-cycle pulse: HI/LO just committed by MULTU/DIVU
stall  output  1  pipeline hold request, combinational = rd_req & busy
hi_out  output  WIDTH  registered HI
lo_out  output  WIDTH  registered LO

Behaviour:
- Clock is clk; reset is synchronous, active-high.
- Reset: state IDLE, counter 0, all working registers 0, hi_out = lo_out = 0, busy = 0, done = 0.
- States: IDLE, MUL, DIV.
- IDLE, start=1, op=MULTU at edge E0:
  - Latch multiplicand = rs_val.
  - Product register {P_hi, P_lo} = {0, rt_val}.
  - count = 0; go to MUL.
- IDLE, start=1, op=DIVU at edge E0:
  - Latch divisor = rt_val.
  - Remainder = 0; quotient register = rs_val.
  - count = 0; go to DIV.
- IDLE, start=1, op=MTHI: hi_out <= rs_val at the same edge; no busy, no done.
- IDLE, start=1, op=MTLO: lo_out <= rs_val at the same edge; no busy, no done.
- MUL step (each edge):
  - If P_lo[0]=1, add multiplicand to P_hi with a (WIDTH+1)-bit sum.
  - Shift {carry, P_hi, P_lo} right by 1; count++.
- DIV step (each edge):
  - Shift {rem, quo} left by 1; trial = rem - divisor as (WIDTH+1)-bit.
  - If no borrow, rem = trial and quo[0] = 1; else quo[0] = 0.
  - count++.
- Commit: on the edge completing iteration WIDTH (edge E0+WIDTH), the result is written and state returns to IDLE.
  - MULTU: hi_out/lo_out <= P_hi/P_lo.
  - DIVU: hi_out <= rem, lo_out <= quo.
- busy = 1 exactly while state is MUL or DIV. That is WIDTH cycles: after E0 up to E0+WIDTH.
- done = 1 for exactly the one cycle following the commit edge.
- Results are visible on hi_out/lo_out from the cycle after E0+WIDTH. MFHI/MFLO issued then needs no stall.
- hi_out/lo_out hold their previous values for the whole operation. Intermediate values never appear on outputs.
- Divide by zero is not trapped; restoring arithmetic yields HI = dividend, LO = all ones. Latency is unchanged.
- start while busy: ignored entirely. Operands, op and the running operation are unaffected. No queueing.
- start and rd_req in the same IDLE cycle: the read sees the pre-operation HI/LO; stall = 0 that cycle.
- start on the commit edge: ignored, because state is not IDLE at that edge.
- Reset mid-operation: abort, return to IDLE, clear HI/LO to 0. No done pulse.
- Reset wins over start at the same edge.
- All arithmetic is unsigned, modulo the stated widths. Carry out of P_hi is kept only through the shift.

Test Plan:
- Reset, then MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> busy high for 32 cycles, done pulses once, hi_out=0xFFFFFFFE lo_out=0x00000001.
- DIVU rs=100 rt=7 -> after 32 busy cycles, lo_out=14 hi_out=2; rd_req asserted during busy gives stall=1 each cycle, stall=0 after commit.
- DIVU rs=5 rt=0 -> hi_out=0x00000005, lo_out=0xFFFFFFFF, latency 32 cycles, done pulse.
- MTHI rs=0x12345678, next cycle MTLO rs=0x9ABCDEF0 -> hi_out/lo_out update one edge after each; busy and done stay 0.
- MULTU 3x4 started; start DIVU 9/3 at busy cycle 10 -> DIVU ignored; result hi=0 lo=12 committed at the original E0+32.
- MULTU 6x7 started, reset asserted at busy cycle 5 -> next cycle busy=0, hi_out=lo_out=0, no done pulse; a new MULTU 2x3 then gives lo_out=6.
